xor_stream_cipher: RTL and testbench

XOR_STREAM_CIPHER -- requirements
Module: xor_stream_cipher

---
 rtl/xor_cipher_pkg.sv | 21 ++
 rtl/xor_key_store.sv | 43 ++++
 rtl/xor_stream_cipher.sv | 118 +++++++++++
 tb/tb_xor_stream_cipher.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR stream cipher.
//   state_e     : controller states (NOKEY, LOAD, RUN)
//   DEF_DATA_W  : default data/key word width
//   DEF_KEY_LEN : default number of words in the rotating key
//   idx_w()     : width of an index into a key of n words (minimum 1 bit)
package xor_cipher_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_KEY_LEN = 4;

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xor_key_store.sv
// Key register file plus load pointer.
//   clk, reset_n : clock, asynchronous active-low reset (clears slots and pointer)
//   we, wdata    : write wdata into slot load_ptr, then advance load_ptr (wraps)
//   rd_idx       : read index, rd_data is the word in that slot (combinational)
//   last_slot    : load_ptr currently points at slot KEY_LEN-1, i.e. the next
//                  write completes a key
module xor_key_store
  import xor_cipher_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int KEY_LEN = DEF_KEY_LEN,
  parameter int IDX_W   = idx_w(KEY_LEN)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              last_slot
);

  logic [DATA_W-1:0] key_q [KEY_LEN];
  logic [IDX_W-1:0]  load_ptr;

  assign last_slot = (load_ptr == IDX_W'(KEY_LEN - 1));
  assign rd_data   = key_q[rd_idx];

  // The pointer wraps back to 0 after the last slot, so it is already 0
  // whenever a new key load begins (from NOKEY or RUN).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_ptr <= '0;
      for (int i = 0; i < KEY_LEN; i++) begin
        key_q[i] <= '0;
      end
    end else if (we) begin
      key_q[load_ptr] <= wdata;
      load_ptr        <= last_slot ? '0 : load_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/xor_stream_cipher.sv
// XOR stream cipher: each accepted input word is XORed with the current word
// of a rotating key and presented one cycle later. Encrypt and decrypt are the
// same operation.
//   clk, reset_n        : clock, asynchronous active-low reset
//   load_key, key_in    : write key_in into the next key slot
//   resync              : return the key index to 0 next cycle
//   in_valid/in_ready   : input handshake, in_data
//   out_valid/out_ready : output handshake, out_data
//   key_valid           : a complete key is loaded (state RUN)
//   state_dbg           : current controller state
//
// Handshake: a word moves on a rising edge where valid & ready are both high.
// valid never depends on ready; once out_valid is high, out_data is held until
// out_ready is seen. in_ready is combinational from state, load_key, out_valid
// and out_ready, so the output register can be refilled in the cycle it drains.
module xor_stream_cipher
  import xor_cipher_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int KEY_LEN = DEF_KEY_LEN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_key,
  input  logic [DATA_W-1:0] key_in,
  input  logic              resync,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              key_valid,
  output state_e            state_dbg
);

  localparam int IDX_W = idx_w(KEY_LEN);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   key_idx;
  logic [DATA_W-1:0]  key_word;
  logic               last_slot;
  logic               xfer;

  xor_key_store #(
    .DATA_W  (DATA_W),
    .KEY_LEN (KEY_LEN),
    .IDX_W   (IDX_W)
  ) u_key_store (
    .clk       (clk),
    .reset_n   (reset_n),
    .we        (load_key),
    .wdata     (key_in),
    .rd_idx    (key_idx),
    .rd_data   (key_word),
    .last_slot (last_slot)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= NOKEY;
    end else begin
      state_q <= state_d;
    end
  end

  // In NOKEY and RUN the load pointer is 0, so last_slot there is only true
  // for a one-word key and a single load completes it.
  always_comb begin
    state_d   = state_q;
    key_valid = 1'b0;
    in_ready  = 1'b0;
    unique case (state_q)
      NOKEY: begin
        if (load_key) state_d = last_slot ? RUN : LOAD;
      end
      LOAD: begin
        if (load_key && last_slot) state_d = RUN;
      end
      RUN: begin
        key_valid = 1'b1;
        in_ready  = !load_key && (!out_valid || out_ready);
        if (load_key) state_d = last_slot ? RUN : LOAD;
      end
      default: state_d = NOKEY;
    endcase
  end

  assign xfer      = in_valid && in_ready;
  assign state_dbg = state_q;

  // Output register: a pending word survives a rekey; it only leaves on
  // out_ready or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ key_word;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Key index: a key load or resync restarts the key; resync beats the
  // advance of a simultaneous transfer (which still used the old index).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_idx <= '0;
    end else if (load_key || resync) begin
      key_idx <= '0;
    end else if (xfer) begin
      key_idx <= (key_idx == IDX_W'(KEY_LEN - 1)) ? '0 : key_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_xor_stream_cipher.sv
module tb_xor_stream_cipher;
  import xor_cipher_pkg::*;

  localparam int DW = 8;
  localparam int KL = 4;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_key = 1'b0;
  logic          resync = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] key_in = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, key_valid;
  logic [DW-1:0] out_data;
  state_e        state_dbg;

  logic          dec_in_valid, dec_in_ready, dec_out_valid, dec_key_valid;
  logic [DW-1:0] dec_out_data;
  state_e        dec_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  xor_stream_cipher #(.DATA_W(DW), .KEY_LEN(KL)) dut (
    .clk(clk), .reset_n(reset_n), .load_key(load_key), .key_in(key_in),
    .resync(resync), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .key_valid(key_valid), .state_dbg(state_dbg)
  );

  // Decryptor chained behind the DUT: same key loads, always ready downstream.
  assign dec_in_valid = out_valid & out_ready;

  xor_stream_cipher #(.DATA_W(DW), .KEY_LEN(KL)) dec (
    .clk(clk), .reset_n(reset_n), .load_key(load_key), .key_in(key_in),
    .resync(1'b0), .in_valid(dec_in_valid), .in_ready(dec_in_ready),
    .in_data(out_data), .out_valid(dec_out_valid), .out_ready(1'b1),
    .out_data(dec_out_data), .key_valid(dec_key_valid), .state_dbg(dec_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- scoreboard / model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rt_q[$];
  int            rt_cyc_q[$];
  logic          rt_en = 1'b0;

  logic [DW-1:0] m_key [KL];
  int            m_lcnt, m_idx;
  logic          m_key_ok, m_ov;
  logic [DW-1:0] m_od;

  always @(negedge clk) begin
    logic          xfer;
    logic [DW-1:0] nd;
    logic [DW-1:0] d;
    int            c;
    if (!reset_n) begin
      for (int i = 0; i < KL; i++) m_key[i] = '0;
      m_lcnt = 0; m_idx = 0; m_key_ok = 0; m_ov = 0; m_od = '0;
      rt_q.delete(); rt_cyc_q.delete();
    end
    check("key_valid", key_valid, m_key_ok);
    check("in_ready", in_ready, m_key_ok && !load_key && (!m_ov || out_ready));
    check("out_valid", out_valid, m_ov);
    if (m_ov) check("out_data", out_data, m_od);

    if (reset_n && m_ov && out_ready) begin
      if (exp_q.size() > 0) check("sb_word", out_data, exp_q.pop_front());
      else check("sb_unexpected_word", out_data, 32'hFFFF_FFFF);
    end

    if (rt_en && dec_in_valid) check("dec_in_ready", dec_in_ready, 1);
    if (rt_en && dec_out_valid) begin
      if (rt_q.size() > 0) begin
        d = rt_q.pop_front();
        c = rt_cyc_q.pop_front();
        check("rt_data", dec_out_data, d);
        check("rt_latency", cyc - c, 2);
      end else begin
        check("rt_unexpected_word", dec_out_data, 32'hFFFF_FFFF);
      end
    end

    if (reset_n) begin
      xfer = in_valid && m_key_ok && !load_key && (!m_ov || out_ready);
      nd   = in_data ^ m_key[m_idx];
      if (rt_en && xfer) begin
        rt_q.push_back(in_data);
        rt_cyc_q.push_back(cyc);
      end
      if (load_key) begin
        m_key[m_lcnt] = key_in;
        m_lcnt   = (m_lcnt + 1) % KL;
        m_key_ok = (m_lcnt == 0);
        m_idx    = 0;
      end else if (resync) begin
        m_idx = 0;
      end else if (xfer) begin
        m_idx = (m_idx + 1) % KL;
      end
      if (xfer) begin
        m_ov = 1'b1;
        m_od = nd;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] k);
    load_key = 1'b1;
    key_in   = k;
    tick();
    load_key = 1'b0;
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic rs);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    resync   = rs;
    #1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    resync   = 1'b0;
    #1;
  endtask

  task automatic drain(input string name);
    repeat (3) tick();
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) tick();
    check("rst_state", state_dbg, NOKEY);
    check("rst_key_valid", key_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    reset_n = 1'b1;
    tick();

    // Key load and rotation
    load(8'hB3);
    check("load1_state", state_dbg, LOAD);
    check("load1_key_valid", key_valid, 0);
    load(8'hAC);
    load(8'h00);
    check("load3_key_valid", key_valid, 0);
    load(8'hFF);
    check("load4_key_valid", key_valid, 1);
    check("load4_state", state_dbg, RUN);
    exp_q.push_back(8'h79); exp_q.push_back(8'hED); exp_q.push_back(8'hFF);
    exp_q.push_back(8'hB0); exp_q.push_back(8'h79);
    send(8'hCA, 0); send(8'h41, 0); send(8'hFF, 0); send(8'h4F, 0); send(8'hCA, 0);
    drain("rotation_drain");

    // Backpressure: key index is 1 (AC)
    exp_q.push_back(8'hBE); exp_q.push_back(8'h34);
    send(8'h12, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h34;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_data", out_data, 8'hBE);
      check("bp_out_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    drain("bp_drain");

    // Resync
    resync = 1'b1;
    tick();
    resync = 1'b0;
    exp_q.push_back(8'h79); exp_q.push_back(8'hED);
    exp_q.push_back(8'h41); exp_q.push_back(8'h79);
    send(8'hCA, 0); send(8'h41, 0); send(8'h41, 1); send(8'hCA, 0);
    drain("resync_drain");

    // Rekey in RUN
    load(8'h55);
    check("rekey_key_valid", key_valid, 0);
    check("rekey_in_ready", in_ready, 0);
    load(8'h66);
    check("rekey2_key_valid", key_valid, 0);
    load(8'h77);
    check("rekey3_key_valid", key_valid, 0);
    check("rekey3_in_ready", in_ready, 0);
    load(8'h88);
    check("rekey4_key_valid", key_valid, 1);

    // Round trip through the chained decryptor
    check("dec_key_valid", dec_key_valid, 1);
    rt_en = 1'b1;
    exp_q.push_back(8'h55); exp_q.push_back(8'h99); exp_q.push_back(8'hD2);
    exp_q.push_back(8'hD2); exp_q.push_back(8'h54); exp_q.push_back(8'hE6);
    exp_q.push_back(8'h4B); exp_q.push_back(8'h4B);
    send(8'h00, 0); send(8'hFF, 0); send(8'hA5, 0); send(8'h5A, 0);
    send(8'h01, 0); send(8'h80, 0); send(8'h3C, 0); send(8'hC3, 0);
    drain("rt_enc_drain");
    check("rt_drain", rt_q.size(), 0);
    rt_en = 1'b0;

    // Reset during LOAD with a pending output word
    out_ready = 1'b0;
    send(8'h99, 0);
    load(8'h11);
    check("rekey_pending_valid", out_valid, 1);
    check("rekey_pending_data", out_data, 8'hCC);
    load(8'h22);
    check("midload_state", state_dbg, LOAD);
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", state_dbg, NOKEY);
    check("mid_rst_key_valid", key_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_dec_state", dec_state, NOKEY);
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();

    // Partial key was discarded: a fresh full load is needed
    load(8'h01);
    load(8'h02);
    check("post_rst_partial_key_valid", key_valid, 0);
    load(8'h03);
    load(8'h04);
    check("post_rst_key_valid", key_valid, 1);
    exp_q.push_back(8'h11);
    send(8'h10, 0);
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
